hazard_ctrl: RTL and testbench

//  Pipeline hazard and multi-cycle-unit controller for the 5-stage MIPS core (F/D/E/M/W).
//  - Decides stall (freezes PC and F/D register, flushes D/E), using Tuse/Tnew compare.
//  - Owns the mult/div busy counter.
//  - Drives forwarding mux selects for the D, E and M stages.

---
 rtl/hazard_ctrl_pkg.sv | 49 ++++
 rtl/hazard_ctrl_md_busy_cnt.sv | 33 +++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions (package pipe_defs) for hazard detection and forwarding.
//  Provides:
//   T_W         width of Tuse/Tnew fields
//   TUSE_NONE   Tuse code meaning "register not read"
//   FWD_*       forwarding mux select codes
//   reg_hit     producer/consumer register match with $0 excluded
//   late_hit    match whose producer is not ready in time (stall term)
//   fwd_sel     youngest-ready-producer select
package pipe_defs;

    localparam int T_W = 2;

    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    // $0 is hardwired to zero, so a write to it is never a hazard source.
    function automatic logic reg_hit(input logic [4:0] r, input logic [4:0] w);
        return (w != 5'd0) && (r == w);
    endfunction

    function automatic logic late_hit(
        input logic [4:0]     r,
        input logic [T_W-1:0] tuse,
        input logic [4:0]     w,
        input logic [T_W-1:0] tnew
    );
        return reg_hit(r, w) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

    // use_e selects whether the E stage is a candidate producer (D-stage consumers only).
    function automatic logic [1:0] fwd_sel(
        input logic [4:0]     r,
        input logic           use_e,
        input logic [4:0]     e_wreg,
        input logic [T_W-1:0] e_tnew,
        input logic [4:0]     m_wreg,
        input logic [T_W-1:0] m_tnew,
        input logic [4:0]     w_wreg
    );
        return (use_e && reg_hit(r, e_wreg) && e_tnew == '0) ? FWD_E :
               (reg_hit(r, m_wreg) && m_tnew == '0)          ? FWD_M :
               reg_hit(r, w_wreg)                            ? FWD_W : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// md_busy_cnt: mult/div unit busy counter; a start loads the op latency, then counts down to idle.
//  Ports:
//   clk       clock
//   reset     synchronous active-high reset, clears the counter
//   start     mult*/div* in E this cycle (reloads even if already busy)
//   op        0 = mult family, 1 = div family
//   busy      counter nonzero
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, MD busy tracking and forwarding selects for the 5-stage F/D/E/M/W core.
//  Optional feature macro: HAZARD_STALL_CNT_EN adds the 32-bit stall_cycles counter output.
//  Ports:
//   clk, reset                  clock, synchronous active-high reset
//   d_rs, d_rt, d_tuse_rs/rt    D sources and their Tuse (3 = not read)
//   d_is_md                     D instruction uses HI/LO/MD unit
//   e_rs, e_rt, e_wreg, e_tnew  E sources, destination, cycles to result
//   e_md_start, e_md_op         mult/div launch in E and its family
//   m_rt, m_wreg, m_tnew        M store-data source, destination, cycles to result
//   w_wreg                      W destination (always ready)
//   stall, pc_en, de_flush      freeze PC+F/D and bubble D/E
//   md_busy                     MD unit busy
//   fwd_d_rs/rt                 0 regfile, 1 W, 2 M, 3 E
//   fwd_e_rs/rt                 0 pipeline, 1 W, 2 M
//   fwd_m_rt                    0 pipeline, 1 W
//   stall_cycles                (HAZARD_STALL_CNT_EN only) count of stalled cycles
module hazard_ctrl
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     d_rs,
    input  logic [4:0]     d_rt,
    input  logic [T_W-1:0] d_tuse_rs,
    input  logic [T_W-1:0] d_tuse_rt,
    input  logic           d_is_md,
    input  logic [4:0]     e_rs,
    input  logic [4:0]     e_rt,
    input  logic [4:0]     e_wreg,
    input  logic [T_W-1:0] e_tnew,
    input  logic           e_md_start,
    input  logic           e_md_op,
    input  logic [4:0]     m_rt,
    input  logic [4:0]     m_wreg,
    input  logic [T_W-1:0] m_tnew,
    input  logic [4:0]     w_wreg,
    output logic           stall,
    output logic           pc_en,
    output logic           de_flush,
    output logic           md_busy,
    output logic [1:0]     fwd_d_rs,
    output logic [1:0]     fwd_d_rt,
    output logic [1:0]     fwd_e_rs,
    output logic [1:0]     fwd_e_rt,
    output logic           fwd_m_rt
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]    stall_cycles
`endif
);

    logic stall_rs, stall_rt, stall_md;

    md_busy_cnt #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_cnt (
        .clk  (clk),
        .reset(reset),
        .start(e_md_start),
        .op   (e_md_op),
        .busy (md_busy)
    );

    assign stall_rs = late_hit(d_rs, d_tuse_rs, e_wreg, e_tnew) ||
                      late_hit(d_rs, d_tuse_rs, m_wreg, m_tnew);
    assign stall_rt = late_hit(d_rt, d_tuse_rt, e_wreg, e_tnew) ||
                      late_hit(d_rt, d_tuse_rt, m_wreg, m_tnew);
    // Any HI/LO access must wait for a launching or running mult/div to finish.
    assign stall_md = d_is_md && (e_md_start || md_busy);

    assign stall    = stall_rs || stall_rt || stall_md;
    assign pc_en    = ~stall;
    assign de_flush = stall;

    assign fwd_d_rs = fwd_sel(d_rs, 1'b1, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg);
    assign fwd_d_rt = fwd_sel(d_rt, 1'b1, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg);
    assign fwd_e_rs = fwd_sel(e_rs, 1'b0, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg);
    assign fwd_e_rt = fwd_sel(e_rt, 1'b0, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg);
    assign fwd_m_rt = reg_hit(m_rt, w_wreg);

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wreg, m_rt, m_wreg, w_wreg;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_md_start, e_md_op;
    logic       stall, pc_en, de_flush, md_busy, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_is_md   (d_is_md),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .e_wreg    (e_wreg),
        .e_tnew    (e_tnew),
        .e_md_start(e_md_start),
        .e_md_op   (e_md_op),
        .m_rt      (m_rt),
        .m_wreg    (m_wreg),
        .m_tnew    (m_tnew),
        .w_wreg    (w_wreg),
        .stall     (stall),
        .pc_en     (pc_en),
        .de_flush  (de_flush),
        .md_busy   (md_busy),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .fwd_m_rt  (fwd_m_rt)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 0;
        e_rs = 0; e_rt = 0; e_wreg = 0; e_tnew = 0; e_md_start = 0; e_md_op = 0;
        m_rt = 0; m_wreg = 0; m_tnew = 0; w_wreg = 0;
    endtask

    initial begin
        int busy_n;
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_pc_en", 32'(pc_en), 1);
        check("rst_flush", 32'(de_flush), 0);
        check("rst_busy", 32'(md_busy), 0);
        check("rst_fwd_d_rs", 32'(fwd_d_rs), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("rst_stall_cycles", stall_cycles, 0);
`endif

        // lw $1 in E, dependent add in D
        e_wreg = 1; e_tnew = 2; d_rs = 1; d_tuse_rs = 1;
        #1;
        check("lw_e_stall", 32'(stall), 1);
        check("lw_e_pc_en", 32'(pc_en), 0);
        check("lw_e_flush", 32'(de_flush), 1);
        tick();
        e_wreg = 0; e_tnew = 0; m_wreg = 1; m_tnew = 1;
        #1;
        check("lw_m_stall", 32'(stall), 0);
        check("lw_m_fwd_d_rs", 32'(fwd_d_rs), 0);
        d_tuse_rs = 0;
        #1;
        check("lw_m_tuse0_stall", 32'(stall), 1);
        d_tuse_rs = 3;
        #1;
        check("tuse_none_stall", 32'(stall), 0);
        idle();
        d_rt = 7; d_tuse_rt = 0; m_wreg = 7; m_tnew = 1;
        #1;
        check("rt_m_stall", 32'(stall), 1);

        // $0 destination is never a hazard
        idle();
        e_wreg = 0; e_tnew = 2; d_rs = 0; d_tuse_rs = 0;
        #1;
        check("r0_stall", 32'(stall), 0);
        check("r0_fwd_d_rs", 32'(fwd_d_rs), 0);

        // D forwarding priority
        idle();
        d_rs = 3; e_wreg = 3; e_tnew = 0; m_wreg = 3; m_tnew = 0; w_wreg = 3;
        #1;
        check("fwd_d_e", 32'(fwd_d_rs), 3);
        e_tnew = 1;
        #1;
        check("fwd_d_m", 32'(fwd_d_rs), 2);
        m_tnew = 1;
        #1;
        check("fwd_d_w", 32'(fwd_d_rs), 1);
        w_wreg = 0;
        #1;
        check("fwd_d_rf", 32'(fwd_d_rs), 0);
        idle();
        d_rt = 9; e_wreg = 9; e_tnew = 0;
        #1;
        check("fwd_d_rt_e", 32'(fwd_d_rt), 3);

        // E / M forwarding
        idle();
        m_wreg = 5; m_tnew = 0; w_wreg = 5; e_rs = 5;
        #1;
        check("fwd_e_rs_m", 32'(fwd_e_rs), 2);
        e_wreg = 5;
        #1;
        check("fwd_e_rs_ignores_e", 32'(fwd_e_rs), 2);
        m_tnew = 1; e_rt = 5;
        #1;
        check("fwd_e_rs_w", 32'(fwd_e_rs), 1);
        check("fwd_e_rt_w", 32'(fwd_e_rt), 1);
        idle();
        m_rt = 5; w_wreg = 5;
        #1;
        check("fwd_m_rt_w", 32'(fwd_m_rt), 1);
        w_wreg = 6;
        #1;
        check("fwd_m_rt_none", 32'(fwd_m_rt), 0);
        m_rt = 0; w_wreg = 0;
        #1;
        check("fwd_m_rt_r0", 32'(fwd_m_rt), 0);

        // div: busy for 10 cycles after start, mflo stalls t..t+10
        idle();
        d_is_md = 1; e_md_start = 1; e_md_op = 1;
        #1;
        check("div_t_stall", 32'(stall), 1);
        check("div_t_busy", 32'(md_busy), 0);
        tick();
        e_md_start = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check($sformatf("div_busy_t%0d", i), 32'(md_busy), 1);
            check($sformatf("div_stall_t%0d", i), 32'(stall), 1);
            tick();
        end
        #1;
        check("div_t11_busy", 32'(md_busy), 0);
        check("div_t11_stall", 32'(stall), 0);

        // mult: busy for exactly 5 cycles (bounded wait)
        idle();
        e_md_start = 1;
        tick();
        e_md_start = 0;
        busy_n = 0;
        for (int i = 0; i < 20 && md_busy; i++) begin
            busy_n++;
            tick();
        end
        check("mult_busy_len", 32'(busy_n), 5);

        // reset in the middle of a mult
        idle();
        d_is_md = 1; e_md_start = 1;
        tick();
        e_md_start = 0;
        tick();
        tick();
        check("mult_mid_busy", 32'(md_busy), 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("mult_rst_busy", 32'(md_busy), 0);
        check("mult_rst_stall", 32'(stall), 0);

`ifdef HAZARD_STALL_CNT_EN
        idle();
        reset = 1;
        tick();
        reset = 0;
        e_wreg = 2; e_tnew = 2; d_rs = 2; d_tuse_rs = 0;
        tick();
        tick();
        tick();
        idle();
        tick();
        tick();
        check("stall_cycles_3", stall_cycles, 3);
        reset = 1;
        tick();
        reset = 0;
        check("stall_cycles_rst", stall_cycles, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
